// File: rtl/eth_pkg.sv
// Shared Ethernet FCS constants and types for the nibble-stream CRC32 generator and checker.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Register value after a good frame plus its FCS has been clocked through
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    APPEND,
    GAP
  } fcs_state_t;

endpackage

// File: rtl/crc32_nib.sv
// One nibble of reflected CRC32, bit 0 first; shared by the FCS generator and checker.
module crc32_nib
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 4; i++) begin
      if (crc_out[0] ^ nib[i])
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/fcs_append.sv
// Nibble-stream pass-through that appends the Ethernet FCS and then holds off for the inter-frame gap.
module fcs_append
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] axiid,
  input  logic       axiiv,
  output logic       axiir,
  output logic [3:0] axiod,
  output logic       axiov,
  output logic       done
);

  fcs_state_t  state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic [27:0] fcs_sr;
  logic [2:0]  nib_cnt;
  logic [7:0]  gap_cnt;

  crc32_nib u_crc32_nib (
    .crc_in  (crc),
    .nib     (axiid),
    .crc_out (crc_next)
  );

  assign fcs = ~crc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      crc     <= CRC32_INIT;
      fcs_sr  <= '0;
      nib_cnt <= '0;
      gap_cnt <= '0;
      axiod   <= '0;
      axiov   <= 1'b0;
      done    <= 1'b0;
      axiir   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          crc <= CRC32_INIT;
          if (axiiv) begin
            axiod <= axiid;
            axiov <= 1'b1;
            crc   <= crc_next;
            state <= PASS;
          end else begin
            axiod <= '0;
            axiov <= 1'b0;
          end
        end
        PASS: begin
          if (axiiv) begin
            axiod <= axiid;
            axiov <= 1'b1;
            crc   <= crc_next;
          end else begin
            // FCS nibble 0 goes out in the slot right after the last payload nibble
            axiod   <= fcs[3:0];
            fcs_sr  <= fcs[31:4];
            axiov   <= 1'b1;
            nib_cnt <= '0;
            axiir   <= 1'b0;
            state   <= APPEND;
          end
        end
        APPEND: begin
          // nib_cnt tracks which FCS nibble is currently on axiod
          if (nib_cnt == 3'd7) begin
            axiod   <= '0;
            axiov   <= 1'b0;
            gap_cnt <= 8'(IFG_CYCLES);
            state   <= GAP;
          end else begin
            axiod   <= fcs_sr[3:0];
            fcs_sr  <= {4'h0, fcs_sr[27:4]};
            nib_cnt <= nib_cnt + 3'd1;
            done    <= (nib_cnt == 3'd6);
          end
        end
        GAP: begin
          axiod <= '0;
          axiov <= 1'b0;
          crc   <= CRC32_INIT;
          // Leaving on the last count gives exactly IFG_CYCLES idle cycles
          if (gap_cnt <= 8'd1) begin
            gap_cnt <= '0;
            axiir   <= 1'b1;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcs_append.sv
// Directed self-checking bench for fcs_append: payload echo, FCS values, gap timing, reset abort.
module tb_fcs_append;

  localparam int unsigned IFG = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] axiid;
  logic       axiiv;
  logic       axiir;
  logic [3:0] axiod;
  logic       axiov;
  logic       done;

  logic [3:0] a2_d;
  logic       a2_v;
  logic       a2_r;
  logic [3:0] a2_od;
  logic       a2_ov;
  logic       a2_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] tx_q[$];
  logic [3:0] out_q[$];
  int rises = 0;
  int dones = 0;
  int done_pos = 0;
  int idle_bad = 0;
  logic prev_v = 1'b0;

  fcs_append #(.IFG_CYCLES(IFG)) dut (
    .clk   (clk),
    .rst   (rst),
    .axiid (axiid),
    .axiiv (axiiv),
    .axiir (axiir),
    .axiod (axiod),
    .axiov (axiov),
    .done  (done)
  );

  fcs_append #(.IFG_CYCLES(1)) dut_ifg1 (
    .clk   (clk),
    .rst   (rst),
    .axiid (a2_d),
    .axiiv (a2_v),
    .axiir (a2_r),
    .axiod (a2_od),
    .axiov (a2_ov),
    .done  (a2_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (axiov) out_q.push_back(axiod);
    if (axiov && !prev_v) rises++;
    if (!axiov && axiod != 4'h0) idle_bad++;
    if (done) begin
      dones++;
      done_pos = out_q.size();
    end
    prev_v = axiov;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [3:0] n);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 4; k++) begin
      c = (c[0] ^ n[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Sends tx_q, waits for done, checks echo/FCS/length and the ready-reassert delay.
  task automatic run_frame(input string tag, input logic use_exp, input logic [31:0] exp_fcs);
    int n;
    int waited;
    int cnt;
    int bad;
    logic [31:0] got_fcs;
    n = tx_q.size();
    out_q.delete();
    rises = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      axiiv = 1'b1;
      axiid = tx_q[i];
      tick;
      if (i == 0) begin
        check({tag, "_lat_v"}, 32'(axiov), 32'd1);
        check({tag, "_lat_d"}, 32'(axiod), 32'(tx_q[0]));
      end
    end
    axiiv = 1'b0;
    axiid = 4'h0;
    waited = 0;
    while (!done && waited < 40) begin
      tick;
      waited++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    cnt = 1;
    tick;
    while (!axiir && cnt < 300) begin
      tick;
      cnt++;
    end
    check({tag, "_len"}, 32'(out_q.size()), 32'(n + 8));
    check({tag, "_contig"}, 32'(rises), 32'd1);
    check({tag, "_done_cnt"}, 32'(dones), 32'd1);
    check({tag, "_done_pos"}, 32'(done_pos), 32'(n + 8));
    check({tag, "_ready_delay"}, 32'(cnt), 32'(IFG + 1));
    if (out_q.size() >= n + 8) begin
      bad = 0;
      for (int i = 0; i < n; i++) if (out_q[i] !== tx_q[i]) bad++;
      check({tag, "_payload"}, 32'(bad), 32'd0);
      got_fcs = '0;
      for (int k = 0; k < 8; k++) got_fcs[4*k +: 4] = out_q[n + k];
      if (use_exp) check({tag, "_fcs"}, got_fcs, exp_fcs);
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] got_fcs;
    int low;
    int waited;
    int cnt;
    logic [7:0] digits [9];

    rst = 1'b1;
    axiid = 4'h0;
    axiiv = 1'b0;
    a2_d = 4'h0;
    a2_v = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_axiov", 32'(axiov), 32'd0);
    check("rst_axiod", 32'(axiod), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_axiir", 32'(axiir), 32'd1);
    tick;

    // "123456789" -> CRC32 check value CBF43926
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    tx_q.delete();
    for (int i = 0; i < 9; i++) begin
      tx_q.push_back(digits[i][3:0]);
      tx_q.push_back(digits[i][7:4]);
    end
    run_frame("ascii9", 1'b1, 32'hCBF43926);

    tx_q.delete();
    tx_q.push_back(4'h0);
    tx_q.push_back(4'h0);
    run_frame("byte00", 1'b1, 32'hD202EF8D);

    // Loopback: running the whole output through CRC32 must land on the residue
    tx_q.delete();
    for (int i = 0; i < 64; i++) tx_q.push_back(4'h5);
    run_frame("fives", 1'b0, 32'h0);
    res = 32'hFFFFFFFF;
    for (int i = 0; i < out_q.size(); i++) res = model_crc(res, out_q[i]);
    check("fives_residue", res, 32'hDEBB20E3);
    res = 32'hFFFFFFFF;
    for (int i = 0; i < out_q.size(); i++)
      res = model_crc(res, (i == 66) ? (out_q[i] ^ 4'h4) : out_q[i]);
    check("fives_flip_kill", 32'(res != 32'hDEBB20E3), 32'd1);

    // Back-to-back with axiiv held high through APPEND and GAP
    out_q.delete();
    rises = 0;
    dones = 0;
    axiiv = 1'b1;
    axiid = 4'h0;
    tick;
    tick;
    axiiv = 1'b0;
    tick;
    axiiv = 1'b1;
    axiid = 4'h7;
    low = 0;
    while (!axiir && low < 100) begin
      low++;
      tick;
    end
    check("b2b_ready_low", 32'(low), 32'(8 + IFG));
    check("b2b_no_accept", 32'(out_q.size()), 32'd10);
    axiid = 4'h0;
    tick;
    tick;
    axiiv = 1'b0;
    waited = 0;
    while (!done && waited < 40) begin
      tick;
      waited++;
    end
    tick;
    check("b2b_len", 32'(out_q.size()), 32'd20);
    check("b2b_runs", 32'(rises), 32'd2);
    check("b2b_dones", 32'(dones), 32'd2);
    if (out_q.size() >= 20) begin
      check("b2b_pay", 32'({out_q[10], out_q[11]}), 32'h00);
      got_fcs = '0;
      for (int k = 0; k < 8; k++) got_fcs[4*k +: 4] = out_q[12 + k];
      check("b2b_fcs", got_fcs, 32'hD202EF8D);
    end
    cnt = 0;
    while (!axiir && cnt < 100) begin
      tick;
      cnt++;
    end

    // Reset mid-frame aborts without emitting an FCS
    axiiv = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      axiid = 4'(i);
      tick;
    end
    rst = 1'b1;
    axiiv = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    out_q.delete();
    dones = 0;
    check("midrst_axiov", 32'(axiov), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_axiir", 32'(axiir), 32'd1);
    for (int i = 0; i < 15; i++) tick;
    check("midrst_no_fcs", 32'(out_q.size()), 32'd0);
    check("midrst_no_done", 32'(dones), 32'd0);

    // IFG_CYCLES=1: ready returns two cycles after done
    a2_v = 1'b1;
    a2_d = 4'h0;
    tick;
    tick;
    a2_v = 1'b0;
    waited = 0;
    while (!a2_done && waited < 40) begin
      tick;
      waited++;
    end
    check("ifg1_done", 32'(a2_done), 32'd1);
    check("ifg1_last_nib", 32'(a2_od), 32'hD);
    cnt = 0;
    while (!a2_r && cnt < 40) begin
      tick;
      cnt++;
    end
    check("ifg1_ready_delay", 32'(cnt), 32'd2);

    check("idle_axiod_zero", 32'(idle_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
